fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one fp_mult instance among NUM_REQ requesters using round-robin arbitration.
- Holds the winning operand pair stable for the multiplier's full operation and drives a single-cycle data_valid.
- Waits a fixed MUL_LATENCY cycles, then returns the result to the winning requester together with a per-operation error flag.
- Sits between the issue logic of the FP unit and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 7, cycles from the mul_valid pulse until mul_result is valid (worst-case normal path).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_a  in  NUM_REQ*32  operand A per requester; slice i = [32*i+31:32*i]
- req_b  in  NUM_REQ*32  operand B per requester
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rsp_valid  out  NUM_REQ  one-hot result pulse to the owner
- rsp_data  out  32  IEEE-754 single-precision product
- rsp_err  out  1  invalid-operation flag for this response
- rsp_id  out  ID_W  index of the responding requester
- busy  out  1  high while an operation is in flight
- mul_a  out  32  operand A to the multiplier
- mul_b  out  32  operand B to the multiplier
- mul_valid  out  1  data_valid to the multiplier
- mul_result  in  32  multiplier output register

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values: all outputs 0, state IDLE, rr pointer 0, latency counter 0.
- FSM:
  - IDLE: if any req_valid, pick the winner by round-robin starting at ptr. Assert req_ready[win] for exactly 1 cycle and latch req_a/req_b/win into registers. Go to ISSUE.
  - ISSUE: mul_valid=1 for exactly one cycle; counter=MUL_LATENCY-1; go to WAIT.
  - WAIT: decrement counter each cycle. At 0, go to RESP.
  - RESP: rsp_valid[id]=1 for one cycle, with rsp_data=mul_result, rsp_id=id, and rsp_err=(mul_result[30:0]==31'h7FFFFFFF). Set ptr=(id+1) mod NUM_REQ. Go to IDLE.
- Per-operation latency: accept to response = MUL_LATENCY+2 cycles. Back-to-back throughput is one operation per MUL_LATENCY+3 cycles.
- mul_a/mul_b hold the latched operands from ISSUE through RESP inclusive. They must not change during this time, because the multiplier samples its operands combinationally in several states.
- req_valid is level; a requester holds valid and operands until it sees req_ready. Dropping req_valid before the grant withdraws the request, with no side effects.
- Requests arriving while busy are not sampled. They are arbitrated at the next IDLE.
- Round-robin: priority order is ptr, ptr+1, ... wrapping at NUM_REQ-1→0. A single persistent requester is granted every time. No starvation: any held request is served within NUM_REQ operations.
- busy = (state != IDLE).
- rsp_err is computed per response; the multiplier's own sticky error output is not used.
- Reset mid-operation: abandon the in-flight operation, issue no response, return to IDLE, ptr=0. mul_valid must be 0 in the cycle after rst deasserts.
- Unknown state encoding → IDLE.

Optional Feature:
- FP_MUL_ARB_STATS_EN defined: adds outputs stat_ops (32-bit, count of responses) and stat_errs (32-bit, count of responses with rsp_err=1).
  - Both counters wrap at 2^32 and clear on rst.
  - Both increment in the RESP cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fp_mul_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - QNAN_MAG = 31'h7FFFFFFF
  - DEF_MUL_LATENCY = 7
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant and encoded index; purely combinational. It is reusable for the adder path.

Test Plan:
- Single request: req_valid[0]=1, a=32'h40000000, b=32'h40400000 → req_ready[0] pulse in cycle 0; rsp_valid[0] at cycle 9 with rsp_data=32'h40C00000, rsp_err=0, rsp_id=0.
- All four requests valid, ptr=0 → grants in order 0,1,2,3. The next round with only requesters 0 and 3 valid grants 0 then 3. Each response is routed to the correct rsp_valid bit.
- NaN operand: a=32'h7FC00000, b=32'h3F800000 → rsp_data=32'h7FFFFFFF, rsp_err=1. The next operation, 1.0×1.0, gives 32'h3F800000 with rsp_err=0.
- Operand stability: after the grant, requester changes req_a to garbage → mul_a stays latched through RESP and the result is unaffected.
- rst asserted during WAIT → no rsp_valid; busy=0 in the next cycle; the next request is served normally with ptr=0.
- With FP_MUL_ARB_STATS_EN: 5 operations, 2 of them NaN → stat_ops=5, stat_errs=2.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types and constants for the FP multiplier sharing logic
// Contents: arbiter FSM state enum, quiet-NaN magnitude pattern, default multiplier latency.
package fp_mul_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} arb_state_t;
  localparam logic [30:0] QNAN_MAG = 31'h7FFFFFFF;
  localparam int DEF_MUL_LATENCY = 7;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, priority ptr_i, ptr_i+1, ... wrapping
// Ports: req_i request vector, ptr_i highest-priority index,
//        grant_o one-hot winner, idx_o encoded winner, valid_o any request present.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);
  logic [ID_W-1:0] j;
  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    j = '0;
    idx_o = '0;
    valid_o = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = ID_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) idx_o = j;
    end
    grant_o = valid_o ? NUM_REQ'(1) << idx_o : '0;
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin sharing of one fixed-latency fp multiplier among NUM_REQ requesters
// Ports: req_valid/req_a/req_b in, req_ready grant pulse out; rsp_valid/rsp_data/rsp_err/rsp_id
//        result pulse to the owner; busy while an operation is in flight; mul_a/mul_b/mul_valid
//        drive the multiplier, mul_result returns its product.
// Option: FP_MUL_ARB_STATS_EN adds stat_ops/stat_errs response counters.
module fp_mul_arbiter import fp_mul_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  output logic                    mul_valid,
  input  logic [31:0]             mul_result
`ifdef FP_MUL_ARB_STATS_EN
  ,
  output logic [31:0]             stat_ops,
  output logic [31:0]             stat_errs
`endif
);
  localparam int CNT_W = $clog2(MUL_LATENCY + 1);
  arb_state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, win;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant;
  logic any, resp;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req_valid), .ptr_i(ptr_q), .grant_o(grant), .idx_o(win), .valid_o(any)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        id_d = win;
        a_d = req_a[{win, 5'b0} +: 32];
        b_d = req_b[{win, 5'b0} +: 32];
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = CNT_W'(MUL_LATENCY - 1);
      end
      WAIT: begin
        state_d = cnt_q == '0 ? RESP : WAIT;
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        ptr_d = id_q == ID_W'(NUM_REQ - 1) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
    end
  end
  assign resp = state_q == RESP;
  // Grant is combinational in IDLE; masked during reset so all outputs read 0.
  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign busy = state_q != IDLE;
  assign mul_valid = state_q == ISSUE;
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign rsp_valid = resp ? NUM_REQ'(1) << id_q : '0;
  assign rsp_data = resp ? mul_result : '0;
  assign rsp_err = resp && mul_result[30:0] == QNAN_MAG;
  assign rsp_id = resp ? id_q : '0;
`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] ops_q, errs_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q <= '0;
      errs_q <= '0;
    end else if (resp) begin
      ops_q <= ops_q + 1'b1;
      errs_q <= errs_q + 32'(rsp_err);
    end
  end
  assign stat_ops = ops_q;
  assign stat_errs = errs_q;
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed self-checking bench with a cycle-level reference model of the arbiter
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int L = 7;
  localparam int IW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*32-1:0] req_a = '0, req_b = '0;
  logic [N-1:0] req_ready, rsp_valid;
  logic [31:0] rsp_data, mul_a, mul_b, mul_result;
  logic rsp_err, busy, mul_valid;
  logic [IW-1:0] rsp_id;
`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] stat_ops, stat_errs;
`endif
  int total = 0, bad = 0;
  int age = 0;
  int dut_g[$], dut_r[$];
  int m_t = 0, m_ptr = 0, m_id = 0, m_ops = 0, m_errs = 0;
  logic [31:0] m_a, m_b, m_e;
  logic [N-1:0] e_rdy;
  fp_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_id(rsp_id), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_result(mul_result)
`ifdef FP_MUL_ARB_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );
  always #5 clk = ~clk;
  // Stand-in multiplier: NaN in -> canonical NaN out, a few exact products, otherwise a fixed scramble.
  function automatic logic [31:0] stub(input logic [31:0] a, input logic [31:0] b);
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FFFFFFF;
    if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
    return a ^ {b[15:0], b[31:16]};
  endfunction
  // Product becomes valid MUL_LATENCY cycles after the mul_valid pulse; garbage before that.
  always @(posedge clk) begin
    if (rst) age <= 0;
    else if (mul_valid) age <= 1;
    else if (age != 0 && age < 100) age <= age + 1;
  end
  assign mul_result = age >= L ? stub(mul_a, mul_b) : 32'hDEADBEEF;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: an operation occupies L+3 cycles counted from its grant (t=0):
  // mul_valid at t=1, response at t=L+2, idle again the cycle after.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_rst", 32'(req_ready), 0);
      m_t = 0; m_ptr = 0; m_ops = 0; m_errs = 0;
    end else begin
      e_rdy = '0;
      if (m_t == 0)
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (e_rdy == 0 && req_valid[j]) begin
            e_rdy[j] = 1'b1; m_id = j; m_a = req_a[32*j +: 32]; m_b = req_b[32*j +: 32];
          end
        end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(m_t != 0));
      chk("mul_valid", 32'(mul_valid), 32'(m_t == 1));
      chk("rsp_valid", 32'(rsp_valid), m_t == L + 2 ? 32'(1 << m_id) : 0);
      if (m_t != 0) begin
        chk("mul_a_hold", mul_a, m_a);
        chk("mul_b_hold", mul_b, m_b);
      end
      if (m_t == L + 2) begin
        m_e = stub(m_a, m_b);
        chk("rsp_data", rsp_data, m_e);
        chk("rsp_err", 32'(rsp_err), 32'(m_e[30:0] == 31'h7FFFFFFF));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        m_ptr = (m_id + 1) % N;
        m_ops++;
        m_errs += int'(m_e[30:0] == 31'h7FFFFFFF);
      end
      m_t = m_t == L + 2 ? 0 : m_t != 0 ? m_t + 1 : int'(e_rdy != 0);
    end
  end
  always @(negedge clk)
    if (!rst)
      for (int k = 0; k < N; k++) begin
        if (req_ready[k]) dut_g.push_back(k);
        if (rsp_valid[k]) dut_r.push_back(k);
      end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask
  // Expected sequence packed as nibbles, element 0 in bits [3:0].
  task automatic chk_seq(input string nm, input int n, input logic [31:0] e);
    logic [31:0] ev;
    ev = e;
    chk({nm, "_gcount"}, dut_g.size(), n);
    chk({nm, "_rcount"}, dut_r.size(), n);
    for (int i = 0; i < n && i < dut_g.size(); i++) chk({nm, "_grant"}, dut_g[i], 32'(ev[4*i +: 4]));
    for (int i = 0; i < n && i < dut_r.size(); i++) chk({nm, "_rsp"}, dut_r[i], 32'(ev[4*i +: 4]));
  endtask
  // Hold each request until granted, then withdraw it; ends once everything has drained.
  task automatic run_group(input logic [N-1:0] m);
    logic [N-1:0] r;
    int n;
    dut_g.delete(); dut_r.delete();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'h41000000 + 32'(i);
      req_b[32*i +: 32] = 32'h3F000010 << i;
    end
    req_valid = m;
    n = 0;
    do begin
      @(negedge clk); r = req_ready;
      step(1); req_valid &= ~r; n++;
    end while ((req_valid != 0 || busy) && n < 300);
    chk("group_drain", 32'(n < 300), 1);
  endtask
  task automatic one_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic ee);
    int n;
    req_a[32*i +: 32] = a; req_b[32*i +: 32] = b; req_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
    chk("op_grant", 32'(req_ready[i]), 1);
    step(1);
    req_valid[i] = 1'b0; req_a[32*i +: 32] = 32'hBAD0BAD0; req_b[32*i +: 32] = 32'h0BAD0BAD;
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == 0 && n < 50);
    chk("op_latency", n, 9);
    chk("op_rsp_valid", 32'(rsp_valid), 32'(1 << i));
    chk("op_rsp_data", rsp_data, ed);
    chk("op_rsp_err", 32'(rsp_err), 32'(ee));
    chk("op_rsp_id", 32'(rsp_id), i);
    step(1);
  endtask
  initial begin
    int n;
    step(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_valid", 32'(mul_valid), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;
    step(1);
    one_op(0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    pulse_rst();
    run_group(4'b1111);
    chk_seq("rr4", 4, 32'h3210);
    run_group(4'b1001);
    chk_seq("rr2", 2, 32'h30);
    one_op(2, 32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 1'b1);
    one_op(2, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    one_op(1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);
    req_a[96 +: 32] = 32'h40000000; req_b[96 +: 32] = 32'h40400000; req_valid[3] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[3] && n < 50);
    step(1); req_valid[3] = 1'b0;
    step(4);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("busy_after_rst", 32'(busy), 0);
    chk("mul_valid_after_rst", 32'(mul_valid), 0);
    n = 0;
    repeat (15) begin @(negedge clk); if (rsp_valid != 0) n++; end
    chk("no_rsp_after_rst", n, 0);
    step(1);
    run_group(4'b1010);
    chk_seq("ptr_after_rst", 2, 32'h31);
    one_op(0, 32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 1'b1);
    one_op(2, 32'h3F800000, 32'h7FC00001, 32'h7FFFFFFF, 1'b1);
    one_op(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0);
    chk("model_ops", m_ops, 5);
    chk("model_errs", m_errs, 2);
`ifdef FP_MUL_ARB_STATS_EN
    chk("stat_ops", stat_ops, 5);
    chk("stat_errs", stat_errs, 2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
